seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//   Parametrised Moore serial-pattern detector. Generalises the fixed 4-bit detectors to any length.
//   Pattern is runtime-loadable, overlap/non-overlap is selectable, and a sample qualifier gates input bits.
//   Sits on a 1-bit serial stream and produces a registered one-cycle match pulse for downstream control logic.
// PARAMETERS
//   PATTERN_LEN  4        pattern length in bits, >= 2
//   PATTERN_RST  4'b1010  pattern loaded at reset, width PATTERN_LEN; x[PATTERN_LEN-1] is the first bit received
//   CNT_W        8        width of match counter (MATCH_CNT_EN only)
// PORTS
//   clk        in   1            rising-edge clock; the only clock
//   rst        in   1            synchronous, active-high reset
//   en         in   1            sample qualifier: x is accepted only on edges with en=1
//   x          in   1            serial data bit
//   overlap    in   1            1 = overlapping detection, 0 = non-overlapping
//   pat_load   in   1            load pat_in as the new pattern on this edge
//   pat_in     in   PATTERN_LEN  new pattern value
//   z          out  1            registered Moore match pulse
//   match_cnt  out  CNT_W        saturating count of matches
// BEHAVIOUR
//   - State: pat_q[PATTERN_LEN-1:0], shreg[PATTERN_LEN-1:0], fill (width $clog2(PATTERN_LEN+1)), z, match_cnt.
//   - Reset (rst=1 at edge, highest priority): pat_q<=PATTERN_RST; shreg<=0; fill<=0; z<=0; match_cnt<=0.
//   - Load (pat_load=1, rst=0): pat_q<=pat_in; shreg<=0; fill<=0; z<=0; en/x are ignored on that edge.
//     match_cnt holds.
//   - Accept (en=1, rst=0, pat_load=0):
//     - shreg_n={shreg[PATTERN_LEN-2:0],x}.
//     - fill_n=min(fill+1,PATTERN_LEN).
//     - hit=(fill_n==PATTERN_LEN)&&(shreg_n==pat_q).
//     - z<=hit; shreg<=shreg_n.
//     - On hit: overlap=1 -> fill<=PATTERN_LEN; overlap=0 -> fill<=0, so the next match needs PATTERN_LEN fresh bits.
//     - Otherwise fill<=fill_n.
//   - Idle (en=0): shreg and fill hold; z<=0.
//   - z is a one-cycle pulse, high in the cycle after the edge that accepted the final pattern bit (latency 1).
//     Back-to-back pulses are possible (e.g. pattern 1111 overlapping).
//   - Before PATTERN_LEN bits have been accepted since reset, load or a non-overlap match, no match is possible.
//   - overlap is sampled only on hit edges; changing it mid-stream affects the next match only.
//   - Reset mid-pattern discards the partial history; pat_q returns to PATTERN_RST.
// CONFIGURATION
//   SEQ_DET_MATCH_CNT_EN defined:
//     - match_cnt increments by 1 on every edge where z is set to 1.
//     - It saturates at 2^CNT_W-1 (no wrap).
//     - It clears only on rst.
//   SEQ_DET_MATCH_CNT_EN undefined: match_cnt is constant 0 and no counter flops are built.
// TESTING
//   1. Defaults, overlap=1, en=1, x=1,0,1,0,1,0 -> z=1 after the 4th and 6th bits only; match_cnt=2.
//   2. overlap=0, x=1,0,1,0,1,0,1,0 -> z=1 after the 4th and 8th bits; no pulse after the 6th.
//   3. overlap=1, x=1,0 / en=0 for 3 cycles (x toggling) / x=1,0 -> a single z pulse after the 4th accepted bit.
//   4. pat_load with pat_in=4'b1101, overlap=1, x=1,1,0,1,1,0,1 -> z after the 4th and 7th bits.
//   5. x=1,0,1 then rst for 1 cycle, then x=0 -> z stays 0; pat_q=1010, match_cnt=0.
//   6. SEQ_DET_MATCH_CNT_EN, CNT_W=2, 5 overlapping matches -> match_cnt sticks at 3.
//      Without the macro -> match_cnt=0 throughout.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// Serial pattern-detector bus: sample qualifier, data bit, mode/pattern controls in; match pulse and count out.
interface seq_detector_param_if #(
  parameter int PATTERN_LEN = 4,
  parameter int CNT_W       = 8
);
  logic                   en;
  logic                   x;
  logic                   overlap;
  logic                   pat_load;
  logic [PATTERN_LEN-1:0] pat_in;
  logic                   z;
  logic [CNT_W-1:0]       match_cnt;

  modport master (
    output en, x, overlap, pat_load, pat_in,
    input  z, match_cnt
  );

  modport slave (
    input  en, x, overlap, pat_load, pat_in,
    output z, match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector, runtime-loadable pattern; z is registered, 1 cycle after the final bit; no backpressure (en qualifies bits).
// SEQ_DET_MATCH_CNT_EN builds a saturating match counter; otherwise match_cnt is tied to 0.
module seq_detector_param #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN_RST = 4'b1010,
  parameter int                     CNT_W       = 8
) (
  input logic                  clk,
  input logic                  rst,
  seq_detector_param_if.slave  bus
);

  localparam int FW = $clog2(PATTERN_LEN + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PATTERN_LEN);

  logic [PATTERN_LEN-1:0] pat_q, pat_d;
  logic [PATTERN_LEN-1:0] shreg, shreg_d, shreg_n;
  logic [FW-1:0]          fill, fill_d, fill_n;
  logic                   z_q, z_d;
  logic                   hit;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= PATTERN_RST;
      shreg <= '0;
      fill  <= '0;
      z_q   <= 1'b0;
    end else begin
      pat_q <= pat_d;
      shreg <= shreg_d;
      fill  <= fill_d;
      z_q   <= z_d;
    end
  end

  // next-state: fill counts accepted bits up to PATTERN_LEN; a match is only possible once full
  always_comb begin
    shreg_n = {shreg[PATTERN_LEN-2:0], bus.x};
    fill_n  = (fill == FILL_FULL) ? fill : fill + FW'(1);
    hit     = (fill_n == FILL_FULL) && (shreg_n == pat_q);

    pat_d   = pat_q;
    shreg_d = shreg;
    fill_d  = fill;
    z_d     = 1'b0;

    if (bus.pat_load) begin
      pat_d   = bus.pat_in;
      shreg_d = '0;
      fill_d  = '0;
    end else if (bus.en) begin
      shreg_d = shreg_n;
      z_d     = hit;
      if (hit) begin
        fill_d = bus.overlap ? FILL_FULL : '0;
      end else begin
        fill_d = fill_n;
      end
    end
  end

  // outputs
  assign bus.z = z_q;

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (z_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios with literal expectations plus randomized traffic vs a history-queue model.
module tb_seq_detector_param;

  localparam int                LEN   = 4;
  localparam int                CW    = 2;
  localparam logic [LEN-1:0]    PRST  = 4'b1010;
  localparam int                MAXC  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detector_param_if #(.PATTERN_LEN(LEN), .CNT_W(CW)) bus ();

  seq_detector_param #(
    .PATTERN_LEN (LEN),
    .PATTERN_RST (PRST),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  // model: pattern, accepted bits since last clear (oldest first), expected outputs
  logic [LEN-1:0] m_pat;
  bit             hist[$];
  logic           m_z;
  int             m_cnt;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic xb, input logic ov,
                      input logic ld, input logic [LEN-1:0] pin);
    bit hit;
    @(negedge clk);
    rst = r; bus.en = e; bus.x = xb; bus.overlap = ov; bus.pat_load = ld; bus.pat_in = pin;
    @(posedge clk);
    if (r) begin
      m_pat = PRST; hist.delete(); m_z = 1'b0; m_cnt = 0;
    end else if (ld) begin
      m_pat = pin; hist.delete(); m_z = 1'b0;
    end else if (e) begin
      hist.push_back(xb);
      if (hist.size() > LEN) void'(hist.pop_front());
      hit = (hist.size() == LEN);
      for (int i = 0; i < hist.size(); i++)
        if (hist[i] != m_pat[LEN-1-i]) hit = 0;
      m_z = hit;
      if (hit) begin
`ifdef SEQ_DET_MATCH_CNT_EN
        if (m_cnt < MAXC) m_cnt++;
`endif
        if (!ov) hist.delete();
      end
    end else begin
      m_z = 1'b0;
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // feed a string of '0'/'1' with en=1; bit i of zm is z after the i-th bit
  task automatic bits(input string s, input logic ov, output logic [31:0] zm);
    zm = '0;
    for (int i = 0; i < s.len(); i++) begin
      step(1'b0, 1'b1, s[i] == 8'h31, ov, 1'b0, '0);
      #1 zm[i] = bus.z;
    end
  endtask

  // per-cycle compare of the DUT against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("z_vs_model", int'(bus.z), int'(m_z));
      check("cnt_vs_model", int'(bus.match_cnt), m_cnt);
    end
  end

  initial begin
    logic [31:0] zm;
    int exp_cnt;
    rst = 1'b1; bus.en = 0; bus.x = 0; bus.overlap = 0; bus.pat_load = 0; bus.pat_in = '0;
    m_pat = PRST; m_z = 0; m_cnt = 0;
    do_reset();
    do_reset();
    chk_on = 1;
    #1;
    check("reset_z", int'(bus.z), 0);
    check("reset_cnt", int'(bus.match_cnt), 0);
    check("reset_pat", int'(dut.pat_q), 4'b1010);

    // 1: overlapping 101010 -> hits after bits 4 and 6
    bits("101010", 1'b1, zm);
    check("t1_zmask", int'(zm), 32'h28);
`ifdef SEQ_DET_MATCH_CNT_EN
    exp_cnt = 2;
`else
    exp_cnt = 0;
`endif
    check("t1_cnt", int'(bus.match_cnt), exp_cnt);

    // 2: non-overlapping 10101010 -> hits after bits 4 and 8
    do_reset();
    bits("10101010", 1'b0, zm);
    check("t2_zmask", int'(zm), 32'h88);

    // 3: en gaps with x toggling do not advance the pattern
    do_reset();
    bits("10", 1'b1, zm);
    check("t3_pre", int'(zm), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, i[0], 1'b1, 1'b0, '0);
      #1 check("t3_idle_z", int'(bus.z), 0);
    end
    bits("10", 1'b1, zm);
    check("t3_zmask", int'(zm), 32'h2);

    // 4: load 1101, overlapping -> hits after bits 4 and 7
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1101);
    #1 check("t4_load_z", int'(bus.z), 0);
    check("t4_pat", int'(dut.pat_q), 4'b1101);
    bits("1101101", 1'b1, zm);
    check("t4_zmask", int'(zm), 32'h48);

    // 5: reset mid-pattern discards history and restores the pattern
    do_reset();
    bits("101", 1'b1, zm);
    do_reset();
    bits("0", 1'b1, zm);
    check("t5_z", int'(zm), 0);
    check("t5_pat", int'(dut.pat_q), 4'b1010);
    check("t5_cnt", int'(bus.match_cnt), 0);

    // 6: five overlapping matches saturate a 2-bit counter
    do_reset();
    bits("101010101010", 1'b1, zm);
    check("t6_zmask", int'(zm), 32'hAA8);
`ifdef SEQ_DET_MATCH_CNT_EN
    exp_cnt = 3;
`else
    exp_cnt = 0;
`endif
    check("t6_cnt", int'(bus.match_cnt), exp_cnt);

    // back-to-back pulses with pattern 1111
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
    bits("111111", 1'b1, zm);
    check("b2b_zmask", int'(zm), 32'h38);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [LEN-1:0] pin;
      int sel;
      pin = LEN'($urandom);
      sel = $urandom_range(0, 3);
      if (sel == 0) pin = 4'b1111;
      else if (sel == 1) pin = 4'b0000;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 7,
           1'($urandom),
           1'($urandom),
           $urandom_range(0, 59) == 0,
           pin);
    end

    @(negedge clk);
    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
